// File: rtl/pipe_reg.sv
// Elastic pipeline register: STAGES valid/ready load-enable stages with collapsing bubbles.
// Define PIPE_REG_SKID_EN to add an input skid entry so ready_o comes straight from a register.
module pipe_reg #(
  parameter int                    ELEM_WIDTH  = 32,
  parameter int                    STAGES      = 2,
  parameter logic [ELEM_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic                          flush_i,
  input  logic [ELEM_WIDTH-1:0]         data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [ELEM_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(STAGES+2)-1:0]   occ_o
);

  localparam int OCC_W = $clog2(STAGES+2);

  logic [STAGES-1:0]     r_v;
  logic [ELEM_WIDTH-1:0] r_d [STAGES];
  logic [STAGES-1:0]     w_en;
  logic [STAGES-1:0]     w_src_v;
  logic [ELEM_WIDTH-1:0] w_src_d [STAGES];
  logic [OCC_W-1:0]      r_occ;
  logic                  w_acc;
  logic                  w_out;

`ifdef PIPE_REG_SKID_EN
  logic                  r_sv;
  logic [ELEM_WIDTH-1:0] r_sd;
`endif

  // Load enables ripple back from the output: a stage may load when it is empty or its word moves on.
  always_comb begin
    logic w_leave;
    w_en    = '0;
    w_leave = ready_i;
    for (int k = STAGES-1; k >= 0; k--) begin
      w_en[k] = ~r_v[k] | w_leave;
      w_leave = w_en[k];
    end
  end

`ifdef PIPE_REG_SKID_EN
  assign ready_o = ~srst_i & ~flush_i & ~r_sv;
`else
  assign ready_o = ~srst_i & ~flush_i & w_en[0];
`endif

  assign w_acc = valid_i & ready_o;
  assign w_out = r_v[STAGES-1] & ready_i;

  always_comb begin
`ifdef PIPE_REG_SKID_EN
    w_src_v[0] = r_sv | w_acc;
    w_src_d[0] = r_sv ? r_sd : data_i;
`else
    w_src_v[0] = w_acc;
    w_src_d[0] = data_i;
`endif
    for (int k = 1; k < STAGES; k++) begin
      w_src_v[k] = r_v[k-1];
      w_src_d[k] = r_d[k-1];
    end
  end

  // Stage registers; data only moves when the incoming word is valid, and freezes during flush.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) r_d[k] <= RESET_VALUE;
    end else if (flush_i) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) r_d[k] <= w_src_d[k];
        end
      end
    end
  end

`ifdef PIPE_REG_SKID_EN
  // Skid holds a word accepted while stage 0 was blocked; it drains first when stage 0 frees.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_sv <= 1'b0;
      r_sd <= RESET_VALUE;
    end else if (flush_i) begin
      r_sv <= 1'b0;
    end else if (r_sv) begin
      if (w_en[0]) r_sv <= 1'b0;
    end else if (w_acc && !w_en[0]) begin
      r_sv <= 1'b1;
      r_sd <= data_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) r_occ <= '0;
    else                   r_occ <= r_occ + OCC_W'(w_acc) - OCC_W'(w_out);
  end

  assign valid_o = r_v[STAGES-1];
  assign data_o  = r_d[STAGES-1];
  assign occ_o   = r_occ;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg (STAGES=2, 8-bit data); follows PIPE_REG_SKID_EN when defined.
module tb_pipe_reg;
  localparam int            W  = 8;
  localparam int            S  = 2;
  localparam logic [W-1:0]  RV = 8'hE5;

  logic         clk = 1'b0;
  logic         srst, flush, valid_i, ready_i, ready_o, valid_o;
  logic [W-1:0] data_i, data_o;
  logic [1:0]   occ_o;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] sb_e;

  pipe_reg #(.ELEM_WIDTH(W), .STAGES(S), .RESET_VALUE(RV)) dut (
    .clk_i(clk), .srst_i(srst), .flush_i(flush), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .occ_o(occ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!srst && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h, want no output", data_o);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_data", data_o, sb_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    repeat (3) cyc();
    chk("rst_ready_low", ready_o, 0);
    srst = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, RV);
    chk("rst_occ_o", occ_o, 0);
    chk("rst_ready_o", ready_o, 1);

    // Streaming 0x11, 0x22, 0x33
    cyc();
    ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h11; exp_q.push_back(8'h11);
    cyc();
    data_i = 8'h22; exp_q.push_back(8'h22);
    #1 chk("lat_not_yet", valid_o, 0);
    cyc();
    data_i = 8'h33; exp_q.push_back(8'h33);
    #1 chk("lat_valid", valid_o, 1);
    chk("lat_data", data_o, 8'h11);
    cyc();
    valid_i = 1'b0;
    #1 chk("stream_nogap_v", valid_o, 1);
    chk("stream_nogap_d", data_o, 8'h22);
    drain("stream");
    cyc();
    chk("stream_occ", occ_o, 0);

    // Backpressure 0xA, 0xB, 0xC
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h0A; exp_q.push_back(8'h0A);
    #1 chk("bp_ready_a", ready_o, 1);
    cyc();
    data_i = 8'h0B; exp_q.push_back(8'h0B);
    #1 chk("bp_ready_b", ready_o, 1);
    cyc();
    data_i = 8'h0C;
    #1;
`ifdef PIPE_REG_SKID_EN
    chk("skid_ready_c", ready_o, 1);
    exp_q.push_back(8'h0C);
    cyc();
    valid_i = 1'b0;
    #1 chk("skid_occ3", occ_o, 3);
    chk("skid_full_ready", ready_o, 0);
    ready_i = 1'b1;
    #1 chk("skid_ready_registered", ready_o, 0);
    ready_i = 1'b0;
    cyc();
    chk("skid_hold_occ", occ_o, 3);
`else
    chk("bp_ready_c", ready_o, 0);
    chk("bp_occ2", occ_o, 2);
    cyc();
    chk("bp_stall_occ", occ_o, 2);
    chk("bp_stall_data", data_o, 8'h0A);
    ready_i = 1'b1; exp_q.push_back(8'h0C);
    #1 chk("bp_release_ready", ready_o, 1);
    cyc();
    valid_i = 1'b0;
`endif
    ready_i = 1'b1;
    drain("bp");
    cyc();
    chk("bp_occ_end", occ_o, 0);

    // Flush with two words held while 0x55 is offered
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h01;
    cyc();
    data_i = 8'h02;
    cyc();
    valid_i = 1'b0;
    #1 chk("fl_pre_occ", occ_o, 2);
    chk("fl_pre_data", data_o, 8'h01);
    valid_i = 1'b1; data_i = 8'h55; flush = 1'b1;
    #1 chk("fl_ready_low", ready_o, 0);
    cyc();
    flush = 1'b0; valid_i = 1'b0;
    chk("fl_occ", occ_o, 0);
    chk("fl_valid_o", valid_o, 0);
    chk("fl_data_hold", data_o, 8'h01);
    ready_i = 1'b1;
    repeat (4) cyc();
    chk("fl_post_occ", occ_o, 0);

    // Reset mid-stream with two words held
    ready_i = 1'b0; valid_i = 1'b1; data_i = 8'h03;
    cyc();
    data_i = 8'h04;
    cyc();
    valid_i = 1'b0;
    #1 chk("mr_pre_occ", occ_o, 2);
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    chk("mr_occ", occ_o, 0);
    chk("mr_data", data_o, RV);
    chk("mr_valid", valid_o, 0);
    ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h77; exp_q.push_back(8'h77);
    cyc();
    valid_i = 1'b0;
    cyc();
    chk("mr_first_valid", valid_o, 1);
    chk("mr_first_data", data_o, 8'h77);
    drain("mr");

    // Sustained throughput
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; data_i = 8'h80 + 8'(i); exp_q.push_back(8'h80 + 8'(i));
      #1 chk("tp_ready", ready_o, 1);
      cyc();
    end
    valid_i = 1'b0;
    #1 chk("tp_valid_streaming", valid_o, 1);
    drain("tp");
    cyc();
    chk("tp_occ_end", occ_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` load-enable registers, each carrying a valid bit, joined by a valid/ready handshake. Bubbles collapse, so throughput is one word per cycle and backpressure stalls the chain. It is the general replacement for single load-enable registers on datapaths that need flow control, for example between the APB register bank and the UART TX/RX paths. A compile-time option adds an input skid buffer so that `ready_o` is driven from a register.

## Interface
- `ELEM_WIDTH`, 32: data width in bits.
- `STAGES`, 2: number of pipeline stages; must be ≥ 1.
- `RESET_VALUE`, '0: value loaded into every stage data register (and the skid data register) on reset; `ELEM_WIDTH` bits wide.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `srst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous flush; discards all held words.
- `data_i`  in  ELEM_WIDTH  upstream data.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  block can accept; a transfer happens when `valid_i & ready_o`.
- `data_o`  out  ELEM_WIDTH  data of the last stage.
- `valid_o`  out  1  last stage holds a word.
- `ready_i`  in  1  downstream accept; a transfer happens when `valid_o & ready_i`.
- `occ_o`  out  $clog2(STAGES+2)  number of words currently held.

## Operation
- Per-stage state: `v[k]` (valid bit) and `d[k]` (data), k = 0..STAGES-1. Stage 0 is the input side; stage STAGES-1 drives `valid_o`/`data_o`.
- Stage k may load (`en[k]`) when it is empty or its word is leaving: `en[k] = ~v[k] | leave[k]`.
- Leave condition for the last stage: `leave[STAGES-1] = ready_i`.
- Leave condition for other stages: `leave[k] = en[k+1]`.
- Stage k loads from stage k-1, or from the input for k = 0.
  - On load, `v[k]` takes the source's valid bit.
  - `d[k]` updates only when the source word is valid (data gating); otherwise it holds its value.
- Without skid: `ready_o = en[0] & ~flush_i`. This is a combinational path from `ready_i`.
- `occ_o` is the count of set valid bits, including the skid entry when present. It is a registered counter updated by +1 per accept and −1 per output transfer, and must always equal the popcount of the valid bits.
- Flush: when `flush_i` is high, all valid bits (and skid valid) clear on the next edge.
  - `occ_o` goes to 0.
  - Data registers hold their values.
  - `ready_o` is 0 during flush, so no input is accepted.
  - The downstream output-side transfer in the flush cycle still counts as delivered.
- Reset (`srst_i`) has priority over flush and handshakes.
  - All valid bits go to 0, `occ_o` goes to 0, and all data registers go to `RESET_VALUE`.
  - Reset mid-stream drops every held word.
- Ordering is strictly FIFO: no word is duplicated or lost except by flush or reset.

## Timing
- Reset values: `valid_o`=0, `data_o`=`RESET_VALUE`, `occ_o`=0.
- `ready_o` is 1 the cycle after reset is released (0 while `srst_i` or `flush_i` is high).
- Latency: a word accepted at edge T appears on `valid_o`/`data_o` after edge T+STAGES-1, i.e. visible from cycle T+STAGES. This holds when the pipeline ahead of it is draining.
- Throughput: with `ready_i` held high, one word per cycle is sustained indefinitely.
- Capacity: STAGES words (STAGES+1 with skid). With `ready_i` low, input stalls (`ready_o`=0) once capacity is reached.
- Bubbles collapse: a word advances into any empty stage ahead of it, even while `ready_i` is low.
- Simultaneous accept and output transfer when full: both occur; `occ_o` is unchanged.

## Configuration
- `PIPE_REG_SKID_EN` defined: adds a one-entry input skid register (`sv`, `sd`).
  - `ready_o = ~sv & ~flush_i`; it is a pure register output with no combinational path from `ready_i`.
  - An accepted word goes into stage 0 if `en[0]` is high; otherwise it goes into the skid.
  - While `sv` is set, stage 0 loads from the skid when `en[0]` is high, and `sv` clears.
  - Capacity becomes STAGES+1; `occ_o` maxima is STAGES+1.
  - Latency is unchanged when the skid is empty.
- `PIPE_REG_SKID_EN` undefined: there is no skid; `ready_o` is combinational as described in Operation, and capacity is STAGES.

## Test plan
- Reset release, STAGES=2: `valid_o`=0, `data_o`=`RESET_VALUE`, `occ_o`=0, `ready_o`=1 on the first cycle after `srst_i` falls.
- Streaming with `ready_i`=1, inputs 0x11, 0x22, 0x33 on consecutive cycles: the same sequence appears on `data_o` with `valid_o`=1, starting 2 cycles after the first accept, with no gaps.
- Backpressure, no skid, STAGES=2: hold `ready_i`=0 and send 0xA, 0xB, 0xC.
  - 0xA and 0xB are accepted; `ready_o` drops and `occ_o`=2.
  - Raise `ready_i`: output is 0xA, 0xB, then 0xC, in order.
- Skid build (`PIPE_REG_SKID_EN`), STAGES=2: same stimulus as the backpressure test.
  - 3 words are accepted and `occ_o`=3.
  - `ready_o` depends only on registered state: toggling `ready_i` in-cycle does not change `ready_o` in that cycle.
- Flush with `occ_o`=2 while `valid_i`=1 carries 0x55: next cycle `occ_o`=0, `valid_o`=0, 0x55 is not accepted, and `data_o` keeps its previous value.
- Reset mid-stream with 2 words held: after the reset edge `occ_o`=0 and `data_o`=`RESET_VALUE`. Subsequent input 0x77 emerges as the first output.
